// File: rtl/prefetch_pkg.sv
// Shared types and default sizing for the instruction prefetch block.
package prefetch_pkg;

  // Default geometry: 13-bit word addresses, 16-bit instructions, 4 entries.
  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PTR_W   = $clog2(DEF_DEPTH);

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the address it came from.
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } entry_t;

endpackage

// File: rtl/prefetch_fetch_ctrl_if.sv
// Bus bundle for the prefetch controller: redirect input, memory read
// handshake and the decode-side valid/ready stream.
// master = the fetch controller, slave = memory/decode environment.
interface prefetch_fetch_ctrl_if #(
  parameter int ADDR_W  = prefetch_pkg::DEF_ADDR_W,
  parameter int INSTR_W = prefetch_pkg::DEF_INSTR_W
);
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr_out, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr_out, instr_pc
  );
endinterface

// File: rtl/prefetch_buffer.sv
// Circular prefetch FIFO. Flush wins over push/pop and empties the buffer
// in one cycle. The head word reads as zero while the buffer is empty.
module prefetch_buffer #(
  parameter int DATA_W = prefetch_pkg::DEF_INSTR_W + prefetch_pkg::DEF_ADDR_W,
  parameter int DEPTH  = prefetch_pkg::DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_occupancy
);
  import prefetch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ZERO_CNT = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Guard the raw requests so the count can never leave 0..DEPTH.
  assign w_do_push = i_push & ~i_flush & (r_count != FULL_CNT);
  assign w_do_pop  = i_pop  & ~i_flush & (r_count != ZERO_CNT);

  // Pointer and occupancy bookkeeping; flush resets both pointers together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= ZERO_PTR;
      r_tail  <= ZERO_PTR;
      r_count <= ZERO_CNT;
    end else if (i_flush) begin
      r_head  <= ZERO_PTR;
      r_tail  <= ZERO_PTR;
      r_count <= ZERO_CNT;
    end else begin
      if (w_do_push) r_tail <= r_tail + ONE_PTR;
      if (w_do_pop)  r_head <= r_head + ONE_PTR;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset since the count gates the output.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_data;
  end

  assign o_head      = (r_count != ZERO_CNT) ? r_mem[r_head] : {DATA_W{1'b0}};
  assign o_occupancy = r_count;

endmodule

// File: rtl/prefetch_fetch_ctrl.sv
// Instruction prefetch controller: runs one memory read at a time ahead of
// decode, fills a circular buffer and flushes on redirect. A redirect that
// arrives while a read is outstanding waits for that read's ack (DISCARD)
// and drops its data before fetching from the new address.
// Optional build macro PREFETCH_STALL_CNT_EN enables the decode starvation
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
module prefetch_fetch_ctrl #(
  parameter int ADDR_W  = prefetch_pkg::DEF_ADDR_W,
  parameter int INSTR_W = prefetch_pkg::DEF_INSTR_W,
  parameter int DEPTH   = prefetch_pkg::DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  prefetch_fetch_ctrl_if.master  bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            stall_cnt
);
  import prefetch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = INSTR_W + ADDR_W;
  localparam logic [PTR_W:0]    ZERO_CNT = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]    LAST_CNT = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_PC   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_PC  = {ADDR_W{1'b0}};

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_disc_addr;
  logic [ADDR_W-1:0] w_disc_addr_nxt;
  logic              w_push;
  logic              w_flush;
  logic              w_pop;
  logic              w_valid;
  logic [PTR_W:0]    w_occ;
  logic [ENT_W-1:0]  w_head;

  // A redirect hides the head so decode cannot consume a stale entry.
  assign w_valid = (w_occ != ZERO_CNT) & ~bus.redirect;
  assign w_pop   = w_valid & bus.instr_ready;

  prefetch_buffer #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      ({bus.mem_rdata, r_fetch_pc}),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_occupancy (w_occ)
  );

  // Next-state, fetch PC and buffer control for the read sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_disc_addr_nxt = r_disc_addr;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      IDLE: begin
        // Any ack seen here has no matching request and is ignored.
        if (bus.redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = bus.redirect_pc;
          w_state_nxt    = REQ;
        end else if ((w_occ != FULL_CNT) || w_pop) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = bus.redirect_pc;
          if (bus.mem_ack) begin
            // The old read completes now; its data is simply not written.
            w_state_nxt = REQ;
          end else begin
            w_disc_addr_nxt = r_fetch_pc;
            w_state_nxt     = DISCARD;
          end
        end else if (bus.mem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + ONE_PC;
          if ((w_occ == LAST_CNT) && !w_pop) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = REQ;
          end
        end else begin
          w_state_nxt = REQ;
        end
      end
      DISCARD: begin
        if (bus.redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = bus.redirect_pc;
        end else begin
          w_fetch_pc_nxt = r_fetch_pc;
        end
        if (bus.mem_ack) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = DISCARD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state, fetch PC and the address of a read being discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= ZERO_PC;
      r_disc_addr <= ZERO_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_disc_addr <= w_disc_addr_nxt;
    end
  end

  // Read address: live fetch PC in REQ, the abandoned address in DISCARD.
  always_comb begin
    bus.mem_addr = ZERO_PC;
    case (r_state)
      REQ:     bus.mem_addr = r_fetch_pc;
      DISCARD: bus.mem_addr = r_disc_addr;
      default: bus.mem_addr = ZERO_PC;
    endcase
  end

  assign bus.mem_req     = (r_state == REQ) || (r_state == DISCARD);
  assign bus.instr_valid = w_valid;
  assign bus.instr_out   = w_head[ENT_W-1:ADDR_W];
  assign bus.instr_pc    = w_head[ADDR_W-1:0];
  assign occupancy       = w_occ;

`ifdef PREFETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles decode asks for work and none is offered; saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (bus.instr_ready && !w_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_prefetch_fetch_ctrl.sv
// Directed bench for prefetch_fetch_ctrl with a small memory responder
// (data = 16'hA000 + address) and hand-computed expectations.
module tb_prefetch_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;

  prefetch_fetch_ctrl_if bus ();

  prefetch_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

`ifdef PREFETCH_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd10;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Responder controls and observation logs
  bit          mem_auto  = 1'b0;
  int          lat       = 0;
  int          req_cycles = 0;
  int          max_occ   = 0;
  logic [12:0] issued [$];
  logic [12:0] popped_pc [$];
  logic [15:0] popped_ins [$];
  int          n_before;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive ack (auto or manual), log pops before the edge,
  // then leave time at posedge+1 for sampling.
  task automatic step(input bit man_ack);
    bus.mem_ack = 1'b0;
    if (man_ack) begin
      bus.mem_ack = 1'b1;
    end else if (mem_auto && bus.mem_req === 1'b1) begin
      req_cycles++;
      if (req_cycles > lat) bus.mem_ack = 1'b1;
    end else if (bus.mem_req !== 1'b1) begin
      req_cycles = 0;
    end
    if (bus.mem_ack) begin
      bus.mem_rdata = 16'hA000 + {3'b000, bus.mem_addr};
      req_cycles = 0;
      if (bus.mem_req === 1'b1) issued.push_back(bus.mem_addr);
    end
    #1;
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      popped_pc.push_back(bus.instr_pc);
      popped_ins.push_back(bus.instr_out);
    end
    @(posedge clk);
    #1;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    mem_auto = 1'b0;
    step(1'b0);
    step(1'b0);
    issued.delete();
    popped_pc.delete();
    popped_ins.delete();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 13'h0000;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    bus.instr_ready = 1'b0;

    // 1: reset state, then fill 0..3 with one-cycle ack latency
    do_reset();
    check_val("rst_mem_req", bus.mem_req, 1'b0);
    check_val("rst_mem_addr", bus.mem_addr, 13'h0000);
    check_val("rst_valid", bus.instr_valid, 1'b0);
    check_val("rst_instr_out", bus.instr_out, 16'h0000);
    check_val("rst_instr_pc", bus.instr_pc, 13'h0000);
    check_val("rst_occ", occupancy, 3'd0);
    check_val("rst_stall", stall_cnt, 16'h0000);
    rst = 1'b1;
    mem_auto = 1'b1;
    lat = 1;
    repeat (12) step(1'b0);
    check_val("fill_count", issued.size(), 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("fill_addr%0d", i), issued[i], i);
    check_val("fill_req_low", bus.mem_req, 1'b0);
    check_val("fill_occ", occupancy, 3'd4);
    check_val("fill_valid", bus.instr_valid, 1'b1);
    check_val("fill_head_ins", bus.instr_out, 16'hA000);
    check_val("fill_head_pc", bus.instr_pc, 13'h0000);

    // 2: stream 8 instructions with immediate acks
    lat = 0;
    max_occ = 0;
    bus.instr_ready = 1'b1;
    repeat (8) step(1'b0);
    bus.instr_ready = 1'b0;
    mem_auto = 1'b0;
    check_val("stream_count", popped_pc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("stream_pc%0d", i), popped_pc[i], i);
      check_val($sformatf("stream_ins%0d", i), popped_ins[i], 16'hA000 + i);
    end
    check_val("stream_max_occ_le4", (max_occ <= 4), 1'b1);

    // 3: redirect while read of addr 4 is pending, ack 3 cycles later
    do_reset();
    rst = 1'b1;
    mem_auto = 1'b1;
    lat = 0;
    for (int i = 0; i < 20 && issued.size() < 3; i++) step(1'b0);
    check_val("pend_fill3", issued.size(), 3);
    bus.instr_ready = 1'b1;
    step(1'b0);
    bus.instr_ready = 1'b0;
    mem_auto = 1'b0;
    check_val("pend_req", bus.mem_req, 1'b1);
    check_val("pend_addr4", bus.mem_addr, 13'h0004);
    check_val("pend_occ", occupancy, 3'd3);
    bus.redirect = 1'b1;
    bus.redirect_pc = 13'h0100;
    step(1'b0);
    bus.redirect = 1'b0;
    check_val("disc_req", bus.mem_req, 1'b1);
    check_val("disc_addr_old", bus.mem_addr, 13'h0004);
    check_val("disc_occ", occupancy, 3'd0);
    check_val("disc_valid", bus.instr_valid, 1'b0);
    step(1'b0);
    step(1'b0);
    check_val("disc_hold_addr", bus.mem_addr, 13'h0004);
    step(1'b1);
    check_val("redir_req", bus.mem_req, 1'b1);
    check_val("redir_addr", bus.mem_addr, 13'h0100);
    check_val("redir_occ", occupancy, 3'd0);
    mem_auto = 1'b1;
    step(1'b0);
    check_val("redir_valid", bus.instr_valid, 1'b1);
    check_val("redir_pc", bus.instr_pc, 13'h0100);
    check_val("redir_ins", bus.instr_out, 16'hA100);

    // 4: redirect to 1FFF from IDLE, fetch wraps to 0000
    for (int i = 0; i < 20 && bus.mem_req === 1'b1; i++) step(1'b0);
    check_val("idle_req_low", bus.mem_req, 1'b0);
    check_val("idle_occ", occupancy, 3'd4);
    bus.redirect = 1'b1;
    bus.redirect_pc = 13'h1FFF;
    #1;
    check_val("redir_masks_valid", bus.instr_valid, 1'b0);
    step(1'b0);
    bus.redirect = 1'b0;
    check_val("wrap_req", bus.mem_req, 1'b1);
    check_val("wrap_addr0", bus.mem_addr, 13'h1FFF);
    check_val("wrap_occ", occupancy, 3'd0);
    issued.delete();
    popped_pc.delete();
    popped_ins.delete();
    bus.instr_ready = 1'b1;
    repeat (3) step(1'b0);
    check_val("wrap_iss0", issued[0], 13'h1FFF);
    check_val("wrap_iss1", issued[1], 13'h0000);
    check_val("wrap_pop0", popped_pc[0], 13'h1FFF);
    check_val("wrap_pop1", popped_pc[1], 13'h0000);

    // 5: redirect + ack + ready in the same cycle
    mem_auto = 1'b0;
    n_before = popped_pc.size();
    bus.redirect = 1'b1;
    bus.redirect_pc = 13'h0ABC;
    #1;
    check_val("same_valid_masked", bus.instr_valid, 1'b0);
    step(1'b1);
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    check_val("same_no_pop", popped_pc.size(), n_before);
    check_val("same_occ", occupancy, 3'd0);
    check_val("same_req", bus.mem_req, 1'b1);
    check_val("same_addr", bus.mem_addr, 13'h0ABC);
    step(1'b1);
    check_val("same_head_pc", bus.instr_pc, 13'h0ABC);
    check_val("same_head_ins", bus.instr_out, 16'hAABC);
    check_val("same_occ1", occupancy, 3'd1);

    // 6: reset mid-request, ignored ack in IDLE, starvation counter
    rst = 1'b0;
    step(1'b0);
    check_val("midreq_drop", bus.mem_req, 1'b0);
    step(1'b0);
    check_val("rst2_occ", occupancy, 3'd0);
    check_val("rst2_stall", stall_cnt, 16'h0000);
    rst = 1'b1;
    bus.instr_ready = 1'b1;
    step(1'b1);
    check_val("idle_ack_ignored", occupancy, 3'd0);
    repeat (9) step(1'b0);
    check_val("stall_cnt10", stall_cnt, EXP_STALL);
    check_val("stall_occ", occupancy, 3'd0);
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 13'h0005;
    step(1'b0);
    bus.redirect = 1'b0;
    check_val("stall_kept_on_redirect", stall_cnt, EXP_STALL);
    check_val("redir_during_req_discard", bus.mem_addr, 13'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prefetch_fetch_ctrl.md
Name: prefetch_fetch_ctrl

Overview:
- Sequences instruction fetch from the 16-bit instruction memory into a 4-entry circular prefetch buffer, running ahead of decode.
- Issues one memory read at a time over a req/ack handshake and auto-increments the fetch PC.
- Serves instructions in order to decode over a valid/ready interface.
- Flushes the buffer and discards any in-flight read on a branch/jump redirect.

Parameters:
- ADDR_W, 13, instruction-memory word-address width; fetch PC wraps modulo 2^ADDR_W.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch buffer entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-low reset.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- mem_req  out  1  read request; held high until mem_ack.
- mem_addr  out  ADDR_W  read address; stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse: mem_rdata is valid this cycle.
- mem_rdata  in  INSTR_W  read data.
- instr_valid  out  1  head entry available to decode.
- instr_ready  in  1  decode accepts the head entry this cycle.
- instr_out  out  INSTR_W  head instruction.
- instr_pc  out  ADDR_W  address of the head instruction.
- occupancy  out  log2(DEPTH)+1  number of valid buffer entries.
- stall_cnt  out  16  starvation counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at posedge) gives:
  - state=IDLE, fetch_pc=0, buffer empty, occupancy=0.
  - mem_req=0, mem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, stall_cnt=0.
  - Reset mid-request drops the request. A mem_ack arriving later in IDLE is ignored.
- States:
  - IDLE: if occupancy<DEPTH, go to REQ next cycle.
  - REQ: mem_req=1, mem_addr=fetch_pc.
    - On mem_ack: write {mem_rdata, fetch_pc} at the buffer tail, fetch_pc<=fetch_pc+1 (wraps), then go to IDLE if full after the write, else stay in REQ and issue the next address on the next cycle.
    - On redirect without mem_ack: go to DISCARD.
  - DISCARD: mem_req stays 1 at the old address until mem_ack. That ack's data is dropped. Then go to REQ at the redirected fetch_pc.
- Pop: when instr_valid & instr_ready, the head pointer advances and occupancy decrements.
- Buffer output:
  - instr_valid = (occupancy!=0) & ~redirect.
  - instr_out/instr_pc come combinationally from the head entry; they read 0 when the buffer is empty.
- Requests are issued only while occupancy<DEPTH, so the buffer never overflows and an ack never finds it full.
- Latency: a redirect at cycle N puts mem_req with redirect_pc at N+1 when no read is in flight. With mem_ack at N+1, instr_valid rises at N+2.
- Redirect handling:
  - Clears the buffer: head=tail, occupancy=0.
  - Sets fetch_pc<=redirect_pc.
  - Any pop in the same cycle is ignored.
  - Redirect together with mem_ack: the ack completes the old read and its data is dropped. Go to REQ at redirect_pc; no DISCARD.
  - Redirect during DISCARD: update fetch_pc, stay in DISCARD.
- Simultaneous events:
  - Ack-write and pop in the same cycle: occupancy unchanged and both pointers advance.
  - Pop from a full buffer with no request outstanding: REQ is entered on the next cycle.
- Pointers are log2(DEPTH) bits with natural wrap. occupancy saturates by construction (0..DEPTH).
- Protocol assertion: mem_ack while mem_req=0 is an error and is ignored.

Optional Feature:
- Macro PREFETCH_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle that instr_ready=1 and instr_valid=0. It saturates at 16'hFFFF, is cleared by reset only, and redirect does not clear it.
- Undefined: stall_cnt is tied to 0 and the counter logic is not built.

Decomposition:
- Package prefetch_pkg:
  - fetch_state_t enum {IDLE, REQ, DISCARD}.
  - Default constants ADDR_W, INSTR_W, DEPTH.
  - PTR_W = log2(DEPTH).
  - Entry typedef {instr, pc}.
- Sub-module prefetch_buffer: circular FIFO with push, pop, flush, head data and occupancy outputs, and a synchronous active-low reset.
- prefetch_fetch_ctrl holds the FSM, fetch_pc, handshake and stall counter.

Test Plan:
- Reset release, mem_ack one cycle after each mem_req with data 16'hA000+addr, instr_ready=0 -> mem_addr 0,1,2,3 issued; then mem_req=0, occupancy=4, instr_out=16'hA000, instr_pc=0.
- Buffer full, instr_ready=1 for 8 cycles with immediate acks -> decode receives pc 0..7 in order, no gaps after the first fill; occupancy never exceeds 4.
- redirect with redirect_pc=13'h100 while a read of addr 4 is pending, ack 3 cycles later -> addr-4 data never appears. Next mem_addr=13'h100 and the first instr_pc=13'h100.
- redirect with redirect_pc=13'h1FFF and no reads in flight -> fetches 13'h1FFF then 13'h0000 (wrap); instr_pc sequence 1FFF, 0000.
- redirect in the same cycle as mem_ack and instr_ready=1 -> no pop occurs, the ack data is dropped, occupancy=0 next cycle, and mem_req goes to redirect_pc.
- With PREFETCH_STALL_CNT_EN, hold mem_ack low for 10 cycles while instr_ready=1 and the buffer is empty -> stall_cnt=10. Without the macro, stall_cnt=0.
